// File: rtl/dual_port_mem_arbiter.sv
// ---------------------------------------------------------------------------
// dual_port_mem_arbiter
//   Shares one single-port synchronous SRAM between an instruction-fetch
//   requester (I, read-only) and a data requester (D, read/write, byte mask).
//   D has fixed priority. A starvation counter forces an I grant after
//   STARVE_LIMIT consecutive D grants while I is waiting. Read data returns
//   one cycle after the grant and is routed to the owning requester by a
//   registered owner tag.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   i_req/i_addr           I request (held until i_gnt), byte address
//   i_gnt/i_rvalid/i_rdata I grant, read-valid (grant+1), read word
//   d_req/d_addr           D request (held until d_gnt), byte address
//   d_wmask/d_wdata        byte write mask (0 = read), pre-aligned write data
//   d_gnt/d_rvalid/d_rdata D grant, read-valid (read grant+1), read word
//   sram_*                 SRAM port; sram_rdata valid the cycle after sram_en
// ---------------------------------------------------------------------------
module dual_port_mem_arbiter #(
  parameter int ADDR_BITS    = 14,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [31:0]          i_rdata,
  input  logic                 d_req,
  input  logic [31:0]          d_addr,
  input  logic [3:0]           d_wmask,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  output logic                 sram_en,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [3:0]           sram_wmask,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic                 vld;
    logic [ADDR_BITS-1:0] addr;
    logic [3:0]           wmask;
    logic [31:0]          wdata;
  } mem_req_t;

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} own_e;

  mem_req_t   i_r, d_r, sel_r;
  logic [3:0] starve_cnt, starve_nxt;
  logic       rd_vld_q, rd_vld_d;
  own_e       rd_own_q, rd_own_d;

  // Word address only; bits above ADDR_BITS+1 are dropped so the SRAM wraps.
  assign i_r = '{vld: i_req, addr: i_addr[ADDR_BITS+1:2], wmask: 4'b0, wdata: 32'b0};
  assign d_r = '{vld: d_req, addr: d_addr[ADDR_BITS+1:2], wmask: d_wmask, wdata: d_wdata};

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_BITS+2], i_addr[1:0],
                              d_addr[31:ADDR_BITS+2], d_addr[1:0]};

  // Grant: D wins unless I has waited out its starvation budget.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (resetn) begin
      if (d_r.vld && (!i_r.vld || starve_cnt != LIM)) d_gnt = 1'b1;
      else if (i_r.vld)                              i_gnt = 1'b1;
    end
  end

  // SRAM port mux; an I grant carries the zeroed mask/data of i_r.
  always_comb begin
    sel_r      = d_gnt ? d_r : i_r;
    sram_en    = i_gnt | d_gnt;
    sram_addr  = sel_r.addr;
    sram_wmask = sel_r.wmask;
    sram_wdata = sel_r.wdata;
  end

  // Counts D grants taken while I waits; any I grant or I idle clears it.
  always_comb begin
    starve_nxt = starve_cnt;
    if (i_gnt || !i_r.vld)               starve_nxt = 4'd0;
    else if (d_gnt && starve_cnt != LIM) starve_nxt = starve_cnt + 4'd1;
  end

  // One-deep read-return stage with owner tag. Writes launch no return.
  always_comb begin
    rd_vld_d = i_gnt | (d_gnt & ~|d_r.wmask);
    rd_own_d = d_gnt ? OWN_D : OWN_I;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= 4'd0;
      rd_vld_q   <= 1'b0;
      rd_own_q   <= OWN_I;
    end else begin
      starve_cnt <= starve_nxt;
      rd_vld_q   <= rd_vld_d;
      rd_own_q   <= rd_own_d;
    end
  end

  // Gating with resetn kills a return that was in flight when reset arrived.
  assign i_rvalid = resetn & rd_vld_q & (rd_own_q == OWN_I);
  assign d_rvalid = resetn & rd_vld_q & (rd_own_q == OWN_D);
  assign i_rdata  = sram_rdata;
  assign d_rdata  = sram_rdata;

endmodule
